fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-side constants and instruction-memory types
package riscv_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic            req;
      logic [XLEN-1:0] addr;
   } imem_req_t;

   typedef struct packed {
      logic            rvalid;
      logic [XLEN-1:0] rdata;
   } imem_rsp_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for fetched entries and request PCs
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty && !flush));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - credit-limited instruction fetch with in-order response queue and redirect drop accounting
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int              FQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            br_selE,
   input  logic [XLEN-1:0] br_targetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pc4D,
   output logic            validD
);
   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [XLEN-1:0] instr_q, instr_d, pcd_q, pcd_d, pc4d_q, pc4d_d;
   logic            valid_q, valid_d;

   imem_req_t       mreq;
   imem_rsp_t       mrsp;
   logic            hs, rsp_live, dec_load, bypass;
   fetch_entry_t    q_wdata, q_head;
   logic            q_push, q_pop, q_full, q_empty;
   logic [CW-1:0]   q_count;
   logic [XLEN-1:0] pc_head;
   logic            pc_full, pc_empty;
   logic [CW-1:0]   pc_count;
   logic            unused_sigs;

   always_comb begin
      mrsp     = '{rvalid: imem_rvalid, rdata: imem_rdata};
      // Outstanding requests reserve queue slots, so a response always has somewhere to land.
      mreq.req = !rst && !stallF && !br_selE &&
                 (({1'b0, q_count} + {1'b0, outstanding_q}) < (CW+1)'(FQ_DEPTH));
      mreq.addr = pc_q;
      hs        = mreq.req && imem_gnt;
      rsp_live  = mrsp.rvalid && (drop_cnt_q == '0);
      dec_load  = !stallD && !flushD && !br_selE;
      bypass    = dec_load && q_empty && rsp_live;
      q_pop     = dec_load && !q_empty;
      q_push    = rsp_live && !bypass;
      q_wdata   = '{pc: pc_head, instr: mrsp.rdata};

      pc_d = pc_q;
      if (br_selE) begin
         pc_d = {br_targetE[XLEN-1:2], 2'b00};
      end else if (hs) begin
         pc_d = pc_q + 32'd4;
      end

      outstanding_d = outstanding_q + CW'(hs) - CW'(mrsp.rvalid);
      drop_cnt_d    = drop_cnt_q;
      // Everything still in flight after a redirect is stale, including earlier drops.
      if (br_selE) begin
         drop_cnt_d = outstanding_q - CW'(mrsp.rvalid);
      end else if (mrsp.rvalid && !rsp_live) begin
         drop_cnt_d = drop_cnt_q - CW'(1);
      end

      instr_d = instr_q;
      pcd_d   = pcd_q;
      pc4d_d  = pc4d_q;
      valid_d = valid_q;
      if (br_selE || flushD) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (q_pop) begin
         instr_d = q_head.instr;
         pcd_d   = q_head.pc;
         pc4d_d  = q_head.pc + 32'd4;
         valid_d = 1'b1;
      end else if (bypass) begin
         instr_d = mrsp.rdata;
         pcd_d   = pc_head;
         pc4d_d  = pc_head + 32'd4;
         valid_d = 1'b1;
      end else if (dec_load) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         instr_q       <= NOP_INSTR;
         pcd_q         <= '0;
         pc4d_q        <= 32'd4;
         valid_q       <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         instr_q       <= instr_d;
         pcd_q         <= pcd_d;
         pc4d_q        <= pc4d_d;
         valid_q       <= valid_d;
      end
   end

   fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_instr_q (
      .clk(clk), .rst(rst),
      .push(q_push), .push_data(q_wdata),
      .pop(q_pop), .pop_data(q_head),
      .flush(br_selE),
      .full(q_full), .empty(q_empty), .count(q_count)
   );

   // Request PCs in issue order; stale requests are flushed on redirect and never popped.
   fetch_fifo #(.WIDTH(XLEN), .DEPTH(FQ_DEPTH)) u_req_pc (
      .clk(clk), .rst(rst),
      .push(hs), .push_data(pc_q),
      .pop(rsp_live), .pop_data(pc_head),
      .flush(br_selE),
      .full(pc_full), .empty(pc_empty), .count(pc_count)
   );

   assign unused_sigs = ^{q_full, pc_full, pc_empty, pc_count, br_targetE[1:0]};

   assign imem_req  = mreq.req;
   assign imem_addr = mreq.addr;
   assign instrD    = instr_q;
   assign pcD       = pcd_q;
   assign pc4D      = pc4d_q;
   assign validD    = valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit with in-order memory model
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          FQ_DEPTH = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stallF, stallD, flushD, br_selE;
   logic [31:0] br_targetE;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic [31:0] instrD, pcD, pc4D;
   logic        validD;

   fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
      .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .br_selE(br_selE), .br_targetE(br_targetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instrD(instrD), .pcD(pcD), .pc4D(pc4D), .validD(validD)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] mpc;
      int unsigned ready;
   } pend_t;
   typedef enum int {K_LOAD, K_HOLD, K_KILL, K_RST} kind_e;

   pend_t       pend[$];
   logic [31:0] exp_q[$];
   kind_e       kind_q[$];
   int unsigned cyc = 0;
   int          stale = 0;
   logic [31:0] issue_pc = RESET_PC;
   int          checks = 0;
   int          errors = 0;
   int          p_sf, p_sd, p_fl, p_br, p_gnt, p_rv;
   int unsigned lat_min, lat_max;
   bit          hs_g;
   logic [31:0] m_instr = NOP;
   logic [31:0] m_pc = 32'h0;
   bit          m_valid = 1'b0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
   endfunction

   function automatic bit rnd(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   function automatic logic [31:0] rand_tgt();
      logic [31:0] t = $urandom_range(0, 4095);
      if (rnd(10)) t = t | 32'hFFFF_F000;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
      end
   endtask

   task automatic do_cycle(input bit frc_br, input logic [31:0] tgt, input bit frc_sd,
                           input bit frc_fl, input bit do_rst);
      bit    rv;
      bit    exp_req;
      pend_t e;
      int    n_busy;
      @(posedge clk);
      #1;
      rst         = do_rst;
      stallF      = rnd(p_sf);
      stallD      = frc_sd || rnd(p_sd);
      flushD      = frc_fl || rnd(p_fl);
      br_selE     = !do_rst && (frc_br || rnd(p_br));
      br_targetE  = frc_br ? tgt : rand_tgt();
      imem_gnt    = rnd(p_gnt);
      rv          = !do_rst && pend.size() > 0 && pend[0].ready <= cyc && rnd(p_rv);
      imem_rvalid = rv;
      imem_rdata  = rv ? memfn(pend[0].addr) : $urandom;
      @(negedge clk);
      n_busy  = pend.size() + exp_q.size();
      exp_req = !do_rst && !stallF && !br_selE && (n_busy < FQ_DEPTH);
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (!do_rst) check("imem_addr", imem_addr, issue_pc);
      hs_g = imem_req && imem_gnt;
      if (do_rst) begin
         pend.delete();
         exp_q.delete();
         stale    = 0;
         issue_pc = RESET_PC;
         kind_q.push_back(K_RST);
      end else begin
         if (rv) begin
            e = pend.pop_front();
            if (stale > 0) stale--;
            else exp_q.push_back(e.mpc);
         end
         if (hs_g) begin
            e.addr  = imem_addr;
            e.mpc   = issue_pc;
            e.ready = cyc + $urandom_range(lat_max, lat_min);
            pend.push_back(e);
            issue_pc = issue_pc + 32'd4;
         end
         if (br_selE) begin
            stale = pend.size();
            exp_q.delete();
            issue_pc = {br_targetE[31:2], 2'b00};
         end
         if (br_selE || flushD) kind_q.push_back(K_KILL);
         else if (stallD)       kind_q.push_back(K_HOLD);
         else                   kind_q.push_back(K_LOAD);
      end
      cyc++;
   endtask

   initial begin : monitor
      kind_e       k;
      logic [31:0] p;
      forever begin
         @(posedge clk);
         #2;
         if (kind_q.size() != 0) begin
            k = kind_q.pop_front();
            case (k)
               K_RST: begin
                  m_valid = 1'b0;
                  m_instr = NOP;
                  m_pc    = 32'h0;
               end
               K_KILL: begin
                  m_valid = 1'b0;
                  m_instr = NOP;
               end
               K_LOAD: begin
                  if (exp_q.size() != 0) begin
                     p       = exp_q.pop_front();
                     m_valid = 1'b1;
                     m_pc    = p;
                     m_instr = memfn(p);
                  end else begin
                     m_valid = 1'b0;
                     m_instr = NOP;
                  end
               end
               default: ;
            endcase
            check("validD", 32'(validD), 32'(m_valid));
            check("instrD", instrD, m_instr);
            if (m_valid || k == K_RST) begin
               check("pcD", pcD, m_pc);
               check("pc4D", pc4D, m_pc + 32'd4);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0; br_selE = 1'b0;
      br_targetE = 32'h0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      p_sf = 0; p_sd = 0; p_fl = 0; p_br = 0; p_gnt = 100; p_rv = 100;
      lat_min = 1; lat_max = 1;

      repeat (3) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         check("issue_back_to_back", 32'(hs_g), 32'd1);
      end
      repeat (4) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      repeat (3) do_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      repeat (6) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      do_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      repeat (4) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      lat_min = 3; lat_max = 3;
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10 && pend.size() < 2; i++) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("two_outstanding", 32'(pend.size()), 32'd2);
      do_cycle(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
      repeat (14) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      lat_min = 1; lat_max = 1;
      do_cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b1, 32'h0000_0203, 1'b0, 1'b0, 1'b0);
      do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("redirect_align", imem_addr, 32'h0000_0200);
      do_cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0);
      repeat (10) do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      p_sf = 15; p_sd = 25; p_fl = 8; p_br = 4; p_gnt = 70; p_rv = 70;
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 10000; i++) begin
         do_cycle(1'b0, 32'h0, 1'b0, 1'b0, $urandom_range(0, 1999) == 0);
      end

      @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
